// File: rtl/defs.sv
// Shared type and constant definitions for the memory-port arbiter.
// Build option: MEM_ARB_RR_EN selects round-robin tie-breaking in mem_arb_pick.
package defs;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_INSTR = 2'd1,
        ARB_DATA  = 2'd2,
        ARB_DONE  = 2'd3
    } memarb_state_t;

    typedef enum logic {
        GRANT_INSTR = 1'b0,
        GRANT_DATA  = 1'b1
    } memarb_grant_t;

    localparam logic [1:0] MEMARB_WORD_OPLEN = 2'b10;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between fetch and data requests.
// MEM_ARB_RR_EN: ties go to the requester that did not win last; otherwise data always wins.
module mem_arb_pick
    import defs::*;
(
    input  logic i_req,
    input  logic d_req,
`ifdef MEM_ARB_RR_EN
    input  logic rr_last,
`endif
    output logic req_any,
    output logic grant
);

    always_comb begin
        req_any = i_req | d_req;
        grant   = GRANT_INSTR;
        if (i_req && d_req) begin
`ifdef MEM_ARB_RR_EN
            grant = (rr_last == GRANT_DATA) ? GRANT_INSTR : GRANT_DATA;
`else
            grant = GRANT_DATA;
`endif
        end else if (d_req) begin
            grant = GRANT_DATA;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the memoryController request port between instruction fetch and load/store.
// Build option: MEM_ARB_RR_EN enables round-robin arbitration (default: data has priority).
//
// Handshake: a requester raises *_enable with stable fields and holds it until its *_valid
// pulse (exactly one cycle); downstream, m_enable and all m_* fields stay constant until
// m_valid is seen, and m_valid is ignored unless a transaction is outstanding.
module mem_arbiter
    import defs::*;
#(
    parameter int ADDR_W = 25
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_enable,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_valid,
    output logic [31:0]       i_result,
    input  logic              d_enable,
    input  logic              d_we,
    input  logic              d_unsigned,
    input  logic [1:0]        d_oplen,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_valid,
    output logic [31:0]       d_result,
    output logic              m_enable,
    output logic              m_we,
    output logic              m_unsigned,
    output logic [1:0]        m_oplen,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_wdata,
    input  logic              m_valid,
    input  logic [31:0]       m_result,
    output logic [1:0]        dbg_state
);

    memarb_state_t state_q, state_d;
    logic          pick_any;
    logic          pick_grant;
    logic          grab;
    logic          done;

`ifdef MEM_ARB_RR_EN
    logic rr_last;
`endif

    mem_arb_pick u_pick (
        .i_req   (i_enable),
        .d_req   (d_enable),
`ifdef MEM_ARB_RR_EN
        .rr_last (rr_last),
`endif
        .req_any (pick_any),
        .grant   (pick_grant)
    );

    always_comb begin
        state_d = state_q;
        grab    = 1'b0;
        done    = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    grab    = 1'b1;
                    state_d = (pick_grant == GRANT_DATA) ? ARB_DATA : ARB_INSTR;
                end
            end
            ARB_INSTR, ARB_DATA: begin
                if (m_valid) begin
                    done    = 1'b1;
                    state_d = ARB_DONE;
                end
            end
            // One dead cycle so the served requester can drop its enable before re-arbitration.
            ARB_DONE: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ARB_IDLE;
        else     state_q <= state_d;
    end

    assign dbg_state = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_enable   <= 1'b0;
            m_we       <= 1'b0;
            m_unsigned <= 1'b0;
            m_oplen    <= 2'b00;
            m_addr     <= '0;
            m_wdata    <= '0;
            i_valid    <= 1'b0;
            d_valid    <= 1'b0;
            i_result   <= '0;
            d_result   <= '0;
`ifdef MEM_ARB_RR_EN
            rr_last    <= GRANT_INSTR;
`endif
        end else begin
            i_valid <= 1'b0;
            d_valid <= 1'b0;
            if (grab) begin
                m_enable <= 1'b1;
                if (pick_grant == GRANT_DATA) begin
                    m_we       <= d_we;
                    m_unsigned <= d_unsigned;
                    m_oplen    <= d_oplen;
                    m_addr     <= d_addr;
                    m_wdata    <= d_wdata;
                end else begin
                    m_we       <= 1'b0;
                    m_unsigned <= 1'b0;
                    m_oplen    <= MEMARB_WORD_OPLEN;
                    m_addr     <= i_addr;
                    m_wdata    <= '0;
                end
`ifdef MEM_ARB_RR_EN
                rr_last <= pick_grant;
`endif
            end
            if (done) begin
                m_enable <= 1'b0;
                if (state_q == ARB_DATA) begin
                    d_result <= m_result;
                    d_valid  <= 1'b1;
                end else begin
                    i_result <= m_result;
                    i_valid  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: random and directed requesters, a latency-randomised downstream
// model and an event-level monitor that checks grants, field latching and result routing.
`timescale 1ns/1ps
module tb_mem_arbiter;
    import defs::*;

    localparam int ADDR_W = 25;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_enable, d_enable, d_we, d_unsigned;
    logic [ADDR_W-1:0] i_addr, d_addr;
    logic [1:0]        d_oplen;
    logic [31:0]       d_wdata;
    logic              i_valid, d_valid;
    logic [31:0]       i_result, d_result;
    logic              m_enable, m_we, m_unsigned;
    logic [1:0]        m_oplen;
    logic [ADDR_W-1:0] m_addr;
    logic [31:0]       m_wdata;
    logic              m_valid;
    logic [31:0]       m_result;
    logic [1:0]        dbg_state;

    mem_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .i_enable(i_enable), .i_addr(i_addr), .i_valid(i_valid), .i_result(i_result),
        .d_enable(d_enable), .d_we(d_we), .d_unsigned(d_unsigned), .d_oplen(d_oplen),
        .d_addr(d_addr), .d_wdata(d_wdata), .d_valid(d_valid), .d_result(d_result),
        .m_enable(m_enable), .m_we(m_we), .m_unsigned(m_unsigned), .m_oplen(m_oplen),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_valid(m_valid), .m_result(m_result),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_req = 0;
    int          n_grant = 0;
    int          lat_force = 0;
    logic        stray = 1'b0;
    logic        mon_en = 1'b0;
    logic [31:0] i_exp_q[$];
    logic [31:0] d_exp_q[$];
    logic        obs_q[$];

    // Stateless downstream memory image: the word at 0x40 holds an instruction.
    function automatic logic [31:0] resp_fn(input logic [ADDR_W-1:0] a, input logic we,
                                            input logic uns, input logic [1:0] ol,
                                            input logic [31:0] wd);
        if (!we && a == 25'h40) return 32'h0000_0013;
        return {7'h0, a} ^ {wd[15:0], wd[31:16]} ^ {we, uns, ol, 28'h05A_50C3};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Downstream controller model
    int   resp_cnt = 0;
    logic resp_busy = 1'b0;
    initial begin
        m_valid  = 1'b0;
        m_result = '0;
        forever begin
            @(posedge clk); #1;
            m_valid = 1'b0;
            if (rst) begin
                resp_busy = 1'b0;
                resp_cnt  = 0;
            end else if (resp_busy) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    m_valid   = 1'b1;
                    m_result  = resp_fn(m_addr, m_we, m_unsigned, m_oplen, m_wdata);
                    resp_busy = 1'b0;
                end
            end else if (m_enable) begin
                resp_busy = 1'b1;
                resp_cnt  = (lat_force != 0) ? lat_force : int'($urandom_range(1, 4));
            end else if (stray) begin
                m_valid  = 1'b1;
                m_result = 32'hBAD0_0000;
                stray    = 1'b0;
            end
        end
    end

    // Monitor / scoreboard
    logic              p_men = 0, p_mv = 0, p_ie = 0, p_de = 0;
    logic              p_dwe = 0, p_duns = 0;
    logic [1:0]        p_dol = 0;
    logic [ADDR_W-1:0] p_ia = 0, p_da = 0;
    logic [31:0]       p_dwd = 0;
    logic [60:0]       l_fields = 0;
    logic              owner = 0;
    logic              rr_m = 0;
    int                cyc = 0;
    int                last_done = -100;

    always @(negedge clk) begin
        logic        exp_rise;
        logic        rise;
        logic        winner;
        logic [31:0] e;
        if (mon_en && !rst) begin
            cyc++;
            check("valid_exclusive", {63'b0, i_valid & d_valid}, 64'd0);
            if (p_men && p_mv) begin
                check("m_enable_drop", {63'b0, m_enable}, 64'd0);
                check("i_valid_done", {63'b0, i_valid}, {63'b0, !owner});
                check("d_valid_done", {63'b0, d_valid}, {63'b0, owner});
                last_done = cyc - 1;
            end else begin
                check("i_valid_idle", {63'b0, i_valid}, 64'd0);
                check("d_valid_idle", {63'b0, d_valid}, 64'd0);
                if (p_men) check("m_enable_hold", {63'b0, m_enable}, 64'd1);
            end
            if (i_valid) begin
                obs_q.push_back(1'b0);
                if (i_exp_q.size() == 0) check("i_unexpected", 64'd1, 64'd0);
                else begin
                    e = i_exp_q.pop_front();
                    check("i_result", {32'b0, i_result}, {32'b0, e});
                end
            end
            if (d_valid) begin
                obs_q.push_back(1'b1);
                if (d_exp_q.size() == 0) check("d_unexpected", 64'd1, 64'd0);
                else begin
                    e = d_exp_q.pop_front();
                    check("d_result", {32'b0, d_result}, {32'b0, e});
                end
            end
            rise     = m_enable && !p_men;
            exp_rise = !p_men && (p_ie || p_de) && (cyc - 1 >= last_done + 2);
            check("grant_rise", {63'b0, rise}, {63'b0, exp_rise});
            if (rise) begin
                n_grant++;
                if (p_ie && p_de) begin
`ifdef MEM_ARB_RR_EN
                    winner = !rr_m;
`else
                    winner = 1'b1;
`endif
                end else begin
                    winner = p_de;
                end
                if (winner) l_fields = {p_dwe, p_duns, p_dol, p_da, p_dwd};
                else        l_fields = {1'b0, 1'b0, 2'b10, p_ia, 32'h0};
                owner = winner;
                rr_m  = winner;
            end
            if (m_enable)
                check("m_fields", {3'b0, m_we, m_unsigned, m_oplen, m_addr, m_wdata},
                      {3'b0, l_fields});
            p_men = m_enable; p_mv = m_valid; p_ie = i_enable; p_de = d_enable;
            p_ia = i_addr; p_dwe = d_we; p_duns = d_unsigned; p_dol = d_oplen;
            p_da = d_addr; p_dwd = d_wdata;
        end else begin
            p_men = 0; p_mv = 0; p_ie = 0; p_de = 0;
            cyc = 0; last_done = -100; rr_m = 0;
        end
    end

    // Drivers
    task automatic wait_valid(input bit is_d, output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (is_d ? d_valid : i_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: no valid within 100 cycles, expected one", is_d ? "d" : "i");
        end
    endtask

    task automatic do_fetch(input logic [ADDR_W-1:0] a);
        bit ok;
        i_addr   = a;
        i_enable = 1'b1;
        i_exp_q.push_back(resp_fn(a, 1'b0, 1'b0, 2'b10, 32'h0));
        n_req++;
        wait_valid(1'b0, ok);
        @(posedge clk); #1;
        i_enable = 1'b0;
        i_addr   = ADDR_W'($urandom);
    endtask

    task automatic do_data(input logic we, input logic uns, input logic [1:0] ol,
                           input logic [ADDR_W-1:0] a, input logic [31:0] wd, input bit keep);
        bit ok;
        d_we = we; d_unsigned = uns; d_oplen = ol; d_addr = a; d_wdata = wd;
        d_enable = 1'b1;
        d_exp_q.push_back(resp_fn(a, we, uns, ol, wd));
        n_req++;
        wait_valid(1'b1, ok);
        @(posedge clk); #1;
        if (!keep) d_enable = 1'b0;
    endtask

    task automatic do_data_rand(input bit keep);
        do_data(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
                ADDR_W'($urandom), $urandom, keep);
    endtask

    task automatic wait_m_enable();
        bit ok = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (m_enable) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("m_enable_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        i_enable = 0; i_addr = 0;
        d_enable = 0; d_we = 0; d_unsigned = 0; d_oplen = 0; d_addr = 0; d_wdata = 0;
        repeat (3) @(negedge clk);
        check("rst_m_enable", {63'b0, m_enable}, 64'd0);
        check("rst_valids", {62'b0, i_valid, d_valid}, 64'd0);
        check("rst_results", {i_result, d_result}, 64'd0);
        check("rst_m_fields", {3'b0, m_we, m_unsigned, m_oplen, m_addr, m_wdata}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // Fetch alone with a 3-cycle downstream latency
        @(posedge clk); #1;
        lat_force = 3;
        do_fetch(25'h40);
        check("fetch_result_0x13", {32'b0, i_result}, 64'h13);

        // Store alone
        @(posedge clk); #1;
        do_data(1'b1, 1'b0, 2'b00, 25'h100, 32'hDEAD_BEEF, 1'b0);
        lat_force = 0;

        // Fetch enable dropped mid-transaction still completes
        begin
            bit ok;
            @(posedge clk); #1;
            i_addr = 25'h1234; i_enable = 1'b1;
            i_exp_q.push_back(resp_fn(25'h1234, 1'b0, 1'b0, 2'b10, 32'h0));
            n_req++;
            wait_m_enable();
            @(posedge clk); #1;
            i_enable = 1'b0;
            wait_valid(1'b0, ok);
        end

        // Stray downstream completion while idle must be ignored
        @(posedge clk); #1;
        stray = 1'b1;
        repeat (4) @(negedge clk);

        // Random concurrent traffic
        for (int r = 0; r < 40; r++) begin
            fork
                begin
                    repeat ($urandom_range(1, 3)) @(posedge clk);
                    #1;
                    do_fetch(ADDR_W'($urandom));
                end
                begin
                    repeat ($urandom_range(1, 3)) @(posedge clk);
                    #1;
                    do_data_rand(1'b0);
                end
            join
        end

        // Reset during a data transaction
        @(posedge clk); #1;
        lat_force = 5;
        d_we = 1'b0; d_unsigned = 1'b0; d_oplen = 2'b01; d_addr = 25'h2222; d_wdata = 0;
        d_enable = 1'b1;
        n_req++;
        wait_m_enable();
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rst_mid_m_enable", {63'b0, m_enable}, 64'd0);
        check("rst_mid_results", {i_result, d_result}, 64'd0);
        d_enable = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst_mid_valids", {62'b0, i_valid, d_valid}, 64'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        lat_force = 0;
        do_fetch(25'h40);

        // Tie: fetch held while data issues three back-to-back requests
        obs_q.delete();
        @(posedge clk); #1;
        fork
            do_fetch(ADDR_W'($urandom));
            begin
                for (int j = 0; j < 3; j++) do_data_rand(j < 2);
            end
        join
        check("tie_count", 64'(obs_q.size()), 64'd4);
        if (obs_q.size() == 4) begin
`ifdef MEM_ARB_RR_EN
            check("tie_order", {60'b0, obs_q[0], obs_q[1], obs_q[2], obs_q[3]}, 64'b1011);
`else
            check("tie_order", {60'b0, obs_q[0], obs_q[1], obs_q[2], obs_q[3]}, 64'b1110);
`endif
        end

        repeat (5) @(negedge clk);
        check("grants_per_request", 64'(n_grant), 64'(n_req));
        check("i_queue_drained", 64'(i_exp_q.size()), 64'd0);
        check("d_queue_drained", 64'(d_exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single request port of `memoryController` between the CPU instruction-fetch path and the load/store data path. It sits between the core sequencer and `memoryController`, so both requesters keep the existing enable/valid handshake unchanged. It latches the winning request, holds it stable downstream until completion, and returns the registered result to the winner only.

## Interface
- `ADDR_W`, 25: downstream and data address width.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous reset, active-high.
- `i_enable`  in  1  instruction fetch request, held until `i_valid`.
- `i_addr`  in  ADDR_W  fetch address.
- `i_valid`  out  1  one-cycle completion pulse to fetch.
- `i_result`  out  32  fetched word.
- `d_enable`  in  1  data request, held until `d_valid`.
- `d_we`, `d_unsigned`  in  1  store select and unsigned-load select.
- `d_oplen`  in  2  access length (byte/half/word).
- `d_addr`  in  ADDR_W  data address.
- `d_wdata`  in  32  store data.
- `d_valid`  out  1  one-cycle completion pulse to data path.
- `d_result`  out  32  load result.
- `m_enable`  out  1  downstream request, held until `m_valid`.
- `m_we`, `m_unsigned`, `m_oplen`, `m_addr`, `m_wdata`  out  1/1/2/ADDR_W/32  latched request fields.
- `m_valid`  in  1  downstream completion pulse.
- `m_result`  in  32  downstream read data.

## Operation
- States: `ARB_IDLE`, `ARB_INSTR`, `ARB_DATA`, `ARB_DONE`.
- IDLE: sample `i_enable`/`d_enable`. If either is set, pick a winner and latch its fields into the `m_*` registers. Assert `m_enable` and go to INSTR or DATA.
- An instruction grant forces `m_we=0`, `m_oplen=2'b10`, `m_unsigned=0`, `m_wdata=0`.
- INSTR/DATA: hold `m_enable` and all `m_*` fields constant. When `m_valid` is high:
  - drop `m_enable`,
  - register `m_result` into the winner's result,
  - pulse the winner's valid for one cycle,
  - go to DONE.
- DONE: lasts one cycle and issues no grant. This lets the served requester deassert its enable before the next arbitration, so there are no duplicate grants. Then go to IDLE.
- Default arbitration is fixed priority, data over instruction.
- Requester enable dropping mid-transaction is not an abort. The transaction completes and the valid pulse is still issued.
- `i_result`/`d_result` hold their last value until overwritten. The loser's result is never written.
- `m_valid` outside INSTR/DATA is ignored.
- Reset (any state): state IDLE; `m_enable`, `i_valid`, `d_valid` = 0; all `m_*` fields, `i_result`, `d_result`, `rr_last` = 0. The downstream controller is reset by the same event.

## Timing
- Request high in cycle 0 while IDLE → `m_enable` high from cycle 1.
- `m_valid` in cycle k → requester valid and result in cycle k+1, with state DONE. The next grant is sampled in cycle k+2, and `m_enable` rises in k+3 at the earliest.
- Arbiter overhead is 2 cycles per access beyond the downstream latency.
- Simultaneous requests in the IDLE sample cycle are resolved per Configuration. A loser's request stays pending and is served after the winner's DONE.
- Valid pulses are exactly one cycle wide. `i_valid` and `d_valid` are never high in the same cycle.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin. A 1-bit `rr_last` records the last winner. On a tie the other requester wins, and `rr_last` updates on every grant.
- `MEM_ARB_RR_EN` not defined: fixed priority, data wins every tie, and no `rr_last` register exists.

## Structure
- Package `defs` gains `memarb_state_t` (the four states) and `memarb_grant_t` (`GRANT_INSTR`, `GRANT_DATA`).
- Package `defs` gains constant `MEMARB_WORD_OPLEN = 2'b10`.
- One combinational sub-module, `mem_arb_pick`, takes the two requests and `rr_last` and returns the grant. All sequential logic stays in `mem_arbiter`.

## Test plan
- Fetch alone: `i_addr=0x0000040` with the downstream model's `m_valid` 3 cycles after `m_enable` → `m_addr=0x40`, `m_we=0`; `i_valid` 1 cycle later with the returned `0x00000013`; `d_valid` stays 0.
- Store alone: `d_we=1`, `d_addr=0x100`, `d_wdata=0xDEADBEEF`, `d_oplen=2'b00` → `m_*` match and stay stable until `m_valid`; `d_valid` pulses once.
- Tie, macro off: both requests held for 3 consecutive transactions → data is granted each time while `d_enable` stays high; fetch is served only after `d_enable` drops.
- Tie, `MEM_ARB_RR_EN` defined: both held → grants alternate D, I, D, I.
- Duplicate-grant guard: requester drops enable in the cycle after its valid → exactly one `m_enable` assertion per request.
- Reset mid-transaction: assert `rst` while in DATA → `m_enable` is 0 immediately with no valid pulse; after release, a new fetch completes normally.
